// File: rtl/note_seq_pkg.sv
// Shared types and song-table entry layout for the note sequencer.
package note_seq_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        GAP
    } seq_state_e;

    localparam int unsigned NOTE_W  = 5;
    localparam int unsigned DUR_W   = 3;
    localparam int unsigned ENTRY_W = 8;

    // Entry layout: {note[7:3], dur_code[2:0]}.
    localparam int unsigned NOTE_MSB = 7;
    localparam int unsigned NOTE_LSB = 3;
    localparam int unsigned DUR_MSB  = 2;
    localparam int unsigned DUR_LSB  = 0;

    localparam logic [NOTE_W-1:0] REST_CODE = 5'd0;
    localparam logic [NOTE_W-1:0] END_CODE  = 5'd31;

    // Note field of a song-table entry.
    function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] e);
        return e[NOTE_MSB:NOTE_LSB];
    endfunction

    // Duration code of a song-table entry.
    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond prescaler: counts 0..T-1 while enabled and flags the last tick.
// ms_tick is decoded from the count register; T must be non-zero.
module ms_prescaler #(
    parameter int unsigned TPM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TPM_W-1:0] T,
    output logic             ms_tick
);

    logic [TPM_W-1:0] cnt;

    assign ms_tick = en && (cnt == (T - TPM_W'(1)));

    // Tick counter: cleared on request, frozen while disabled, wraps at T-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= ms_tick ? '0 : cnt + TPM_W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks a (note, duration) song table and drives the tone
// generator, with an inter-note gap, stop, end-of-song and looping.
// Optional macro SEQ_PAUSE_EN adds a pause input that freezes timing in
// PLAY/GAP and mutes the tone.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned BASE_MS = 50,
    parameter int unsigned GAP_MS  = 10,
    parameter int unsigned TPM_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TPM_W-1:0]   ticks_per_milli,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
`ifdef SEQ_PAUSE_EN
    input  logic               pause,
`endif
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic [NOTE_W-1:0]  note_code,
    output logic               tone_en,
    output logic               busy,
    output logic               song_done
);

    // Millisecond counter must hold the longest note and the gap.
    localparam int unsigned MAX_NOTE_MS = BASE_MS << 7;
    localparam int unsigned MAX_MS      = (MAX_NOTE_MS > GAP_MS) ? MAX_NOTE_MS : GAP_MS;
    localparam int unsigned MS_W        = $clog2(MAX_MS + 1);

    seq_state_e        state;
    logic [TPM_W-1:0]  t_cap;
    logic [MS_W-1:0]   ms_left;

    logic              freeze_c;
    logic              timed_c;
    logic              ms_tick;
    logic              ms_done_c;
    logic [NOTE_W-1:0] dec_note_c;
    logic [DUR_W-1:0]  dec_dur_c;

`ifdef SEQ_PAUSE_EN
    assign freeze_c = pause;
`else
    assign freeze_c = 1'b0;
`endif

    assign timed_c    = (state == PLAY) || (state == GAP);
    assign ms_done_c  = ms_tick && (ms_left == MS_W'(1));
    assign dec_note_c = entry_note(rom_data);
    assign dec_dur_c  = entry_dur(rom_data);

    ms_prescaler #(
        .TPM_W (TPM_W)
    ) u_ms_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!timed_c),
        .en      (timed_c && !freeze_c),
        .T       (t_cap),
        .ms_tick (ms_tick)
    );

    // Sequencer FSM with registered outputs; stop from any active state wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            t_cap     <= TPM_W'(1);
            ms_left   <= '0;
            rom_addr  <= '0;
            note_code <= '0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            song_done <= 1'b0;
        end else begin
            song_done <= 1'b0;
            if (state != IDLE && stop) begin
                state     <= IDLE;
                ms_left   <= '0;
                rom_addr  <= '0;
                note_code <= '0;
                tone_en   <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            t_cap    <= (ticks_per_milli == '0) ? TPM_W'(1) : ticks_per_milli;
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= DECODE;
                    end
                    DECODE: begin
                        if (dec_note_c == END_CODE) begin
                            rom_addr <= '0;
                            if (loop_en) begin
                                state <= FETCH;
                            end else begin
                                busy      <= 1'b0;
                                song_done <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            ms_left   <= MS_W'(BASE_MS << dec_dur_c);
                            note_code <= dec_note_c;
                            tone_en   <= (dec_note_c != REST_CODE);
                            state     <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (ms_done_c) begin
                            tone_en <= 1'b0;
                            if (GAP_MS == 0) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= FETCH;
                            end else begin
                                ms_left <= MS_W'(GAP_MS);
                                state   <= GAP;
                            end
                        end else begin
                            if (ms_tick) begin
                                ms_left <= ms_left - MS_W'(1);
                            end
                            tone_en <= (note_code != REST_CODE) && !freeze_c;
                        end
                    end
                    GAP: begin
                        tone_en <= 1'b0;
                        if (ms_done_c) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end else if (ms_tick) begin
                            ms_left <= ms_left - MS_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: table-driven songs, hand-written corner cases and
// randomized songs, all checked against a song-level behavioural model.
`timescale 1ns/1ps
module tb_note_sequencer;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned TPM_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [TPM_W-1:0] tpm = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
`ifdef SEQ_PAUSE_EN
    logic             pause = 1'b0;
`endif

    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [7:0]        rdata_a, rdata_b;
    logic [4:0]        note_a, note_b;
    logic              tone_a, tone_b, busy_a, busy_b, done_a, done_b;

    logic [7:0] rom [4];

    int errors = 0;
    int checks = 0;

    logic [4:0]  hold_a = '0;
    logic [4:0]  hold_b = '0;
    logic [11:0] mq[$];
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    always #5 clk = ~clk;

    // Synchronous song ROMs, one per instance.
    always_ff @(posedge clk) begin
        rdata_a <= rom[addr_a];
        rdata_b <= rom[addr_b];
    end

    note_sequencer #(.ADDR_W(ADDR_W), .BASE_MS(2), .GAP_MS(1), .TPM_W(TPM_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .start(start), .stop(stop),
        .loop_en(loop_en),
`ifdef SEQ_PAUSE_EN
        .pause(pause),
`endif
        .rom_addr(addr_a), .rom_data(rdata_a), .note_code(note_a), .tone_en(tone_a),
        .busy(busy_a), .song_done(done_a));

    note_sequencer #(.ADDR_W(ADDR_W), .BASE_MS(2), .GAP_MS(0), .TPM_W(TPM_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .start(start), .stop(stop),
        .loop_en(loop_en),
`ifdef SEQ_PAUSE_EN
        .pause(pause),
`endif
        .rom_addr(addr_b), .rom_data(rdata_b), .note_code(note_b), .tone_en(tone_b),
        .busy(busy_b), .song_done(done_b));

    // Output snapshot: {addr, note, tone_en, busy, song_done}.
    function automatic logic [11:0] pack(input int a, input logic [4:0] n,
                                         input bit te, input bit bs, input bit dn);
        return {4'(a), n, te, bs, dn};
    endfunction

    function automatic logic [7:0] ent(input int n, input int d);
        return 8'((n << 3) | d);
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got={addr,note,tone,busy,done}=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    // Song-level model: expands the table into per-cycle outputs from start.
    task automatic build(input int gap_ms, input int t_in, input bit lp, input int n,
                         input int stop_at, input logic [4:0] hold0);
        int t, addr, nt, d;
        bit fin;
        logic [4:0] hold;
        t = (t_in == 0) ? 1 : t_in;
        addr = 0;
        fin = 0;
        hold = hold0;
        mq.delete();
        while (mq.size() < n) begin
            if (fin) begin
                mq.push_back(pack(0, hold, 0, 0, 0));
                continue;
            end
            mq.push_back(pack(addr, hold, 0, 1, 0));
            mq.push_back(pack(addr, hold, 0, 1, 0));
            nt = int'(rom[addr][7:3]);
            d  = int'(rom[addr][2:0]);
            if (nt == 31) begin
                addr = 0;
                if (!lp) begin
                    mq.push_back(pack(0, hold, 0, 0, 1));
                    fin = 1;
                end
                continue;
            end
            hold = 5'(nt);
            repeat ((2 << d) * t) mq.push_back(pack(addr, hold, nt != 0, 1, 0));
            repeat (gap_ms * t) mq.push_back(pack(addr, hold, 0, 1, 0));
            addr = (addr + 1) % 4;
        end
        while (mq.size() > n) void'(mq.pop_back());
        if (stop_at >= 0 && stop_at < n - 1 && mq[stop_at][1]) begin
            for (int i = stop_at + 1; i < n; i++) mq[i] = pack(0, 0, 0, 0, 0);
        end
    endtask

    function automatic logic [4:0] next_hold(input logic [11:0] e);
        return e[1] ? 5'd0 : e[7:3];
    endfunction

    // Plays one song on both instances and compares every cycle.
    task automatic run(input string nm, input logic [31:0] img, input int t_in,
                       input bit lp, input int ncyc, input int stop_at);
        for (int i = 0; i < 4; i++) rom[i] = img[8*i +: 8];
        build(1, t_in, lp, ncyc + 1, stop_at, hold_a);
        qa = mq;
        build(0, t_in, lp, ncyc + 1, stop_at, hold_b);
        qb = mq;
        @(negedge clk);
        tpm = 16'(t_in);
        loop_en = lp;
        start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk({nm, "_a"}, c, pack(int'(addr_a), note_a, tone_a, busy_a, done_a), qa[c]);
            chk({nm, "_b"}, c, pack(int'(addr_b), note_b, tone_b, busy_b, done_b), qb[c]);
            stop = (c == stop_at);
            if (c == 2) tpm = tpm + 16'd3;
            if (c == 5 && qa[5][1] && qb[5][1]) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        hold_a = next_hold(qa[ncyc]);
        hold_b = next_hold(qb[ncyc]);
    endtask

    typedef struct packed {
        logic [31:0] img;
        logic [15:0] t;
        logic        lp;
        logic [7:0]  ncyc;
        logic [7:0]  stop_at;   // 8'hFF = no stop
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{img: {8'hF8, 8'hF8, 8'hF8, 8'h29}, t: 16'd4, lp: 1'b0, ncyc: 8'd30, stop_at: 8'hFF};
        vt[1] = '{img: {8'hF8, 8'hF8, 8'hF8, 8'h00}, t: 16'd4, lp: 1'b0, ncyc: 8'd24, stop_at: 8'hFF};
        vt[2] = '{img: {8'hF8, 8'hF8, 8'hF8, 8'h18}, t: 16'd4, lp: 1'b1, ncyc: 8'd60, stop_at: 8'hFF};
        vt[3] = '{img: {8'hF8, 8'hF8, 8'hF8, 8'h29}, t: 16'd4, lp: 1'b0, ncyc: 8'd14, stop_at: 8'd6};
        vt[4] = '{img: {8'hF8, 8'hF8, 8'hF8, 8'h38}, t: 16'd0, lp: 1'b0, ncyc: 8'd12, stop_at: 8'hFF};
        vt[5] = '{img: {8'h20, 8'h18, 8'h10, 8'h08}, t: 16'd1, lp: 1'b0, ncyc: 8'd60, stop_at: 8'hFF};
        for (int i = 0; i < 4; i++) rom[i] = 8'hF8;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_a", 0, pack(int'(addr_a), note_a, tone_a, busy_a, done_a), 12'h000);
        chk("reset_b", 0, pack(int'(addr_b), note_b, tone_b, busy_b, done_b), 12'h000);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven songs.
        for (int v = 0; v < 6; v++) begin
            run($sformatf("vec%0d", v), vt[v].img, int'(vt[v].t), vt[v].lp,
                int'(vt[v].ncyc), (vt[v].stop_at == 8'hFF) ? -1 : int'(vt[v].stop_at));
        end

        // start and stop together while idle: stays idle.
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop = 1'b0;
            chk("start_stop_a", c, pack(int'(addr_a), note_a, tone_a, busy_a, done_a),
                pack(0, hold_a, 0, 0, 0));
            chk("start_stop_b", c, pack(int'(addr_b), note_b, tone_b, busy_b, done_b),
                pack(0, hold_b, 0, 0, 0));
        end

        // Reset mid-song returns outputs immediately.
        rom[0] = ent(9, 1);
        rom[1] = ent(31, 0);
        tpm = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_a", 0, pack(int'(addr_a), note_a, tone_a, busy_a, done_a), 12'h000);
        chk("mid_reset_b", 0, pack(int'(addr_b), note_b, tone_b, busy_b, done_b), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        hold_a = '0;
        hold_b = '0;
        @(negedge clk);

`ifdef SEQ_PAUSE_EN
        // Pause mid-note: tone muted while paused, audible time unchanged.
        begin
            int hi_a, hi_b, hi_pause, ndone;
            hi_a = 0; hi_b = 0; hi_pause = 0; ndone = 0;
            rom[0] = ent(5, 1);
            rom[1] = ent(31, 0);
            tpm = 16'd4;
            loop_en = 1'b0;
            start = 1'b1;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (tone_a) hi_a++;
                if (tone_b) hi_b++;
                if (tone_a && c >= 7 && c <= 16) hi_pause++;
                if (done_a) ndone++;
                pause = (c >= 6 && c <= 15);
            end
            pause = 1'b0;
            checks++;
            if (hi_a != 16) begin errors++; $display("FAIL pause_tone_a got=%0d expected=16", hi_a); end
            checks++;
            if (hi_b != 16) begin errors++; $display("FAIL pause_tone_b got=%0d expected=16", hi_b); end
            checks++;
            if (hi_pause != 0) begin errors++; $display("FAIL pause_mute got=%0d expected=0", hi_pause); end
            checks++;
            if (ndone != 1 || busy_a) begin
                errors++;
                $display("FAIL pause_end done_pulses=%0d busy=%0b expected 1 and 0", ndone, busy_a);
            end
            hold_a = 5'd5;
            hold_b = 5'd5;
        end
`endif

        // Randomized songs.
        for (int r = 0; r < 25; r++) begin
            logic [31:0] img;
            int n;
            for (int i = 0; i < 4; i++) begin
                n = ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(0, 30));
                img[8*i +: 8] = ent(n, int'($urandom_range(0, 2)));
            end
            run($sformatf("rand%0d", r), img, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                80, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 79)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
